seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter SCAN_TICKS, default 50000: clk cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter BLINK_TICKS, default 25000000: clk cycles per blink half-period; legal range 2..2^32.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; one clock, asynchronous assert, active-low.
REQ-005 wr_valid  input  1  write request for one digit.
REQ-006 wr_ready  output  1  write accepted when wr_valid & wr_ready on a rising edge.
REQ-007 wr_digit  input  2  target digit index 0..3.
REQ-008 wr_code  input  5  bit4 = blank; bits3:0 = hex glyph 0..F.
REQ-009 wr_blink  input  1  digit blinks when set.
REQ-010 display_out  output  11  bits10:7 = digit enables, active-low, digit i on bit 7+i; bits6:0 = segments {a,b,c,d,e,f,g}, active-low.
REQ-011 frame_tick  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Function
REQ-012 Slot counter shall count 0..SCAN_TICKS-1 and wrap; wrap cycle = slot end.
REQ-013 Digit select sel shall advance 0->1->2->3->0 at each slot end; no other sequence.
REQ-014 frame_tick shall be 1 exactly in the cycle after the slot end where sel changes 3->0.
REQ-015 display_out shall be registered: value for current sel appears one cycle after sel updates; exactly one enable bit is low at any time outside reset.
REQ-016 Segment field shall be seg7_decode(live[sel].code) unless the digit is blanked (code bit4 = 1, or blink active per REQ-024); then bits6:0 = 7'b1111111, enable still low.
REQ-017 Two digit buffers: shadow (written by port) and live (drives display); each entry = {code[4:0], blink}.
REQ-018 Accepted write shall update shadow[wr_digit] and set pending; wr_ready = !pending.
REQ-019 At the slot end where sel goes 3->0 with pending = 1, live shall load the whole shadow and pending clears; wr_ready returns to 1 the following cycle.
REQ-020 Write latency: new glyph is first shown in the digit-0 slot of the first frame after commit; no partial-frame (torn) update.
REQ-021 wr_valid while wr_ready = 0 shall be ignored; requester holds wr_valid/fields until accepted.
REQ-022 Accepted write during the commit cycle is impossible (ready low); write accepted in the cycle of a 3->0 slot end with pending = 0 sets pending and commits at the next frame end.

Reset
REQ-023 With rst_n = 0: slot and blink counters 0, sel = 0, display_out = 11'h7FF, frame_tick = 0, pending = 0, wr_ready = 1, all shadow/live entries = {5'h10, 0}; first enabled digit is digit 0 one cycle after rst_n release; reset mid-frame discards any pending write.

Configuration
REQ-024 With SEG7_BLINK_EN defined: blink counter counts 0..BLINK_TICKS-1 and toggles phase at wrap (phase resets to 0); digit with live blink = 1 is blanked while phase = 1.
REQ-025 Without SEG7_BLINK_EN: no blink counter/phase logic; blink bits are stored but ignored; digits never blink.

Structure
REQ-026 Package seg7_pkg shall hold code width (5), BLANK code 5'h10, blank segment constant 7'h7F, digit-enable-off constant 4'hF, and the 16-entry hex glyph table.
REQ-027 Sub-module seg7_decode: combinational 5-bit code -> 7-bit active-low segments using seg7_pkg table; BLANK and any bit4 = 1 -> 7'h7F.

Verification (SCAN_TICKS = 4, BLINK_TICKS = 16)
REQ-028 Release reset, no writes -> enables cycle 1110,1101,1011,0111 every 4 cycles, segments 7'h7F, frame_tick every 16 cycles.
REQ-029 Write digit 2 code 5'h08 mid-frame -> wr_ready low until frame end; digit 2 shows 7'b0000000 only from the next frame; digits 0,1 of current frame unchanged.
REQ-030 Hold wr_valid with digit 1 code 5'h01 while pending -> not accepted until wr_ready = 1, then digit 1 shows 7'b1001111 one frame later.
REQ-031 SEG7_BLINK_EN defined, digit 0 code 5'h00 blink = 1 -> digit 0 alternates 7'b0000001 / 7'h7F every 16 cycles; undefined -> steady 7'b0000001.
REQ-032 Assert rst_n = 0 mid-slot with pending write -> display_out 11'h7FF immediately; after release all digits blank, wr_ready = 1.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg -- shared constants and types for the 4-digit 7-segment scanner.
//   CODE_W       : width of a digit code (bit4 = blank, bits3:0 = hex glyph)
//   BLANK_CODE   : code that shows nothing
//   SEG_BLANK    : all segments off (active-low)
//   DIG_OFF      : all digit enables off (active-low)
//   GLYPH_TABLE  : hex glyph -> segments {a,b,c,d,e,f,g}, active-low
//   digit_t      : one digit buffer entry {code, blink}
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam int CODE_W = 5;

  localparam logic [CODE_W-1:0] BLANK_CODE = 5'h10;
  localparam logic [6:0]        SEG_BLANK  = 7'h7F;
  localparam logic [3:0]        DIG_OFF    = 4'hF;

  // Segment order {a,b,c,d,e,f,g}; a 0 lights the segment.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              blink;
  } digit_t;

  localparam digit_t DIGIT_RST = '{code: BLANK_CODE, blink: 1'b0};

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode -- combinational digit code to active-low segment pattern.
//   code_i [4:0] : bit4 = blank, bits3:0 = hex glyph
//   seg_o  [6:0] : segments {a,b,c,d,e,f,g}, active-low; all off when blank
// -----------------------------------------------------------------------------
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [6:0]        seg_o
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    seg_o = SEG_BLANK;
    if (!code_i[CODE_W-1]) begin
      seg_o = GLYPH_TABLE[code_i[3:0]];
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl -- time-multiplexed 4-digit 7-segment display controller
// with a double-buffered digit store (shadow written by the port, live shown).
// A frame is digits 0..3, SCAN_TICKS clocks each. Pending shadow contents are
// copied to live only at the frame boundary, so a frame is never torn.
//
// Optional feature: define SEG7_BLINK_EN to enable per-digit blinking with a
// half-period of BLINK_TICKS clocks. Without it the blink bits are stored but
// have no effect.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   wr_valid/ready   : write handshake; ready is low while a write is pending
//   wr_digit [1:0]   : target digit
//   wr_code  [4:0]   : bit4 = blank, bits3:0 = hex glyph
//   wr_blink         : digit blinks when set
//   display_out[10:0]: [10:7] digit enables (active-low, digit i on bit 7+i),
//                      [6:0] segments {a..g} (active-low); registered
//   frame_tick       : one-cycle pulse after the scan wraps from digit 3 to 0
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_TICKS  = 50000,
  parameter logic [32:0] BLINK_TICKS = 33'd25000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [1:0]        wr_digit,
  input  logic [CODE_W-1:0] wr_code,
  input  logic              wr_blink,
  output logic [10:0]       display_out,
  output logic              frame_tick
);

  localparam int                SLOT_W    = $clog2(SCAN_TICKS);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_TICKS - 1);

  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]        sel_q, sel_d;
  logic              pending_q, pending_d;
  logic              frame_tick_q;
  logic [10:0]       display_q, display_d;
  digit_t            shadow_q [4];
  digit_t            shadow_d [4];
  digit_t            live_q   [4];
  digit_t            live_d   [4];

  logic       slot_end, frame_end, wr_fire;
  digit_t     cur;
  logic [6:0] glyph_seg;
  logic       blink_blank;

  assign slot_end  = (slot_cnt_q == SLOT_LAST);
  assign frame_end = slot_end && (sel_q == 2'd3);
  assign wr_ready  = !pending_q;
  assign wr_fire   = wr_valid && !pending_q;

  always_comb begin
    slot_cnt_d = slot_end ? '0 : slot_cnt_q + 1'b1;
    sel_d      = slot_end ? sel_q + 2'd1 : sel_q;
    pending_d  = pending_q;
    shadow_d   = shadow_q;
    live_d     = live_q;
    if (wr_fire) begin
      shadow_d[wr_digit] = '{code: wr_code, blink: wr_blink};
      pending_d          = 1'b1;
    end
    // Commit and accept never coincide: a commit needs pending, accept needs !pending.
    if (frame_end && pending_q) begin
      live_d    = shadow_q;
      pending_d = 1'b0;
    end
  end

  // Display path: decode the digit currently selected from the live buffer.
  assign cur = live_q[sel_q];

  seg7_decode u_decode (
    .code_i (cur.code),
    .seg_o  (glyph_seg)
  );

`ifdef SEG7_BLINK_EN
  localparam int                 BLINK_W    = $clog2(BLINK_TICKS);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 33'd1);

  logic [BLINK_W-1:0] blink_cnt_q;
  logic               phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign blink_blank = cur.blink & phase_q;
`else
  logic unused_blink;
  assign unused_blink = cur.blink;
  assign blink_blank  = 1'b0;
`endif

  always_comb begin
    display_d = {~(4'b0001 << sel_q), (blink_blank ? SEG_BLANK : glyph_seg)};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q   <= '0;
      sel_q        <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      display_q    <= {DIG_OFF, SEG_BLANK};
      // NOTE: the small digit buffers are reset explicitly so the display is
      // guaranteed blank after reset and a discarded write cannot leak later.
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= DIGIT_RST;
        live_q[i]   <= DIGIT_RST;
      end
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      sel_q        <= sel_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_end;
      display_q    <= display_d;
      shadow_q     <= shadow_d;
      live_q       <= live_d;
    end
  end

  assign display_out = display_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl -- scoreboard bench for seg7_scan_ctrl with SCAN_TICKS = 4
// and BLINK_TICKS = 16 (one frame = 16 clocks). The stimulus process pushes the
// expected display word of every digit slot; the monitor pops one word each time
// the DUT presents a new digit enable and compares. frame_tick and the one-hot
// enable field are checked every cycle against the frame arithmetic.
// Expected glyphs depend on SEG7_BLINK_EN exactly as the RTL build does.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int unsigned SCAN  = 4;
  localparam logic [32:0] BLINK = 33'd16;

  localparam logic [6:0] S_BL = 7'h7F;
  localparam logic [6:0] S_0  = 7'b0000001;
  localparam logic [6:0] S_1  = 7'b1001111;
  localparam logic [6:0] S_8  = 7'b0000000;
  localparam logic [6:0] S_A  = 7'b0001000;
  localparam logic [6:0] S_C  = 7'b0110001;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [1:0]  wr_digit = 2'd0;
  logic [4:0]  wr_code  = 5'd0;
  logic        wr_blink = 1'b0;
  logic [10:0] display_out;
  logic        frame_tick;

  seg7_scan_ctrl #(
    .SCAN_TICKS  (SCAN),
    .BLINK_TICKS (BLINK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_digit    (wr_digit),
    .wr_code     (wr_code),
    .wr_blink    (wr_blink),
    .display_out (display_out),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  // Rising edges since the last reset release.
  int unsigned edge_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, edge %0d)", name, act, exp, $time, edge_cnt);
    end
  endtask

  function automatic logic [10:0] slot_word(input int d, input logic [6:0] seg);
    logic [3:0] en;
    en    = 4'hF;
    en[d] = 1'b0;
    return {en, seg};
  endfunction

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    exp_q.push_back(slot_word(0, s0));
    exp_q.push_back(slot_word(1, s1));
    exp_q.push_back(slot_word(2, s2));
    exp_q.push_back(slot_word(3, s3));
  endtask

  task automatic goto_edge(input int unsigned n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  // Monitor: per-cycle frame_tick / one-hot checks, per-slot scoreboard pop.
  initial begin : monitor
    logic [3:0]  prev_en;
    logic [3:0]  en;
    logic [10:0] exp_w;
    prev_en = 4'hF;
    forever begin
      @(negedge clk);
      en = display_out[10:7];
      if (!rst_n) begin
        prev_en = 4'hF;
      end else if (edge_cnt != 0) begin
        check("frame_tick", {31'd0, frame_tick}, {31'd0, (edge_cnt % 16) == 0});
        check("enable_onehot", $countones(~en), 1);
        if (en != prev_en && exp_q.size() > 0) begin
          exp_w = exp_q.pop_front();
          check("slot_display", {21'd0, display_out}, {21'd0, exp_w});
        end
        prev_en = en;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_display", {21'd0, display_out}, 32'h7FF);
    check("rst_frame_tick", {31'd0, frame_tick}, 0);
    check("rst_wr_ready", {31'd0, wr_ready}, 1);

    push_frame(S_BL, S_BL, S_BL, S_BL);  // F0: idle, all blank
    push_frame(S_BL, S_BL, S_BL, S_BL);  // F1: digit 2 written mid-frame, not yet live
    push_frame(S_BL, S_BL, S_8,  S_BL);  // F2: digit 2 committed
    push_frame(S_BL, S_1,  S_8,  S_BL);  // F3: held digit 1 write committed
    push_frame(S_0,  S_1,  S_8,  S_BL);  // F4: digit 0 blinking, phase 0
`ifdef SEG7_BLINK_EN
    push_frame(S_BL, S_1,  S_8,  S_BL);  // F5: phase 1 blanks digit 0
`else
    push_frame(S_0,  S_1,  S_8,  S_BL);  // F5: blink ignored
`endif
    push_frame(S_0,  S_1,  S_8,  S_BL);  // F6

    #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_digit0", {21'd0, display_out}, {21'd0, slot_word(0, S_BL)});

    // Digit 2 <- 8, accepted at edge 22 (digit-1 slot of frame 1).
    goto_edge(21);
    wr_valid = 1'b1; wr_digit = 2'd2; wr_code = 5'h08; wr_blink = 1'b0;
    @(negedge clk);
    check("ready_low_after_write", {31'd0, wr_ready}, 0);
    // Immediately request digit 1 <- 1 and hold it while pending.
    wr_digit = 2'd1; wr_code = 5'h01;
    goto_edge(31);
    check("ready_low_before_commit", {31'd0, wr_ready}, 0);
    @(negedge clk);
    check("ready_high_after_commit", {31'd0, wr_ready}, 1);
    @(negedge clk);  // held request accepted at edge 33
    wr_valid = 1'b0;
    check("ready_low_held_accept", {31'd0, wr_ready}, 0);

    // Digit 0 <- 0 with blink, accepted at edge 50, commits at edge 64.
    goto_edge(49);
    check("ready_before_blink_write", {31'd0, wr_ready}, 1);
    wr_valid = 1'b1; wr_digit = 2'd0; wr_code = 5'h00; wr_blink = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; wr_blink = 1'b0;

    // Pending write, then reset mid-slot.
    goto_edge(112);
    check("queue_drained_1", exp_q.size(), 0);
    wr_valid = 1'b1; wr_digit = 2'd3; wr_code = 5'h05;
    @(negedge clk);
    wr_valid = 1'b0;
    check("ready_low_pending", {31'd0, wr_ready}, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_display", {21'd0, display_out}, 32'h7FF);
    check("midrst_wr_ready", {31'd0, wr_ready}, 1);
    check("midrst_frame_tick", {31'd0, frame_tick}, 0);

    repeat (3) @(negedge clk);
    push_frame(S_BL, S_BL, S_BL, S_BL);  // F0: pending write discarded
    push_frame(S_BL, S_BL, S_BL, S_A);   // F1: digit 3 committed, others blank
    push_frame(S_BL, S_BL, S_BL, S_A);   // F2: frame-end write not yet live
    push_frame(S_BL, S_C,  S_BL, S_A);   // F3: frame-end write committed
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_digit0_after_rst", {21'd0, display_out}, {21'd0, slot_word(0, S_BL)});
    check("ready_after_rst", {31'd0, wr_ready}, 1);

    // Digit 3 <- A, accepted at edge 3, commits at edge 16.
    goto_edge(2);
    wr_valid = 1'b1; wr_digit = 2'd3; wr_code = 5'h0A;
    @(negedge clk);
    wr_valid = 1'b0;

    // Digit 1 <- C accepted exactly at the frame-end edge 32 with nothing pending.
    goto_edge(31);
    check("ready_at_frame_end", {31'd0, wr_ready}, 1);
    wr_valid = 1'b1; wr_digit = 2'd1; wr_code = 5'h0C;
    @(negedge clk);
    wr_valid = 1'b0;
    check("ready_low_frame_end_write", {31'd0, wr_ready}, 0);
    goto_edge(47);
    check("ready_low_until_next_frame", {31'd0, wr_ready}, 0);
    @(negedge clk);
    check("ready_high_next_frame", {31'd0, wr_ready}, 1);

    goto_edge(64);
    check("queue_drained_2", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
